maze_player_ctrl: RTL



---
 rtl/maze_pkg.sv | 41 ++++
 rtl/maze_player_ctrl_if.sv | 27 ++
 rtl/maze_rom.sv | 29 ++
 rtl/maze_player_ctrl.sv | 150 +++++++++++++++
 4 files changed

// File: rtl/maze_pkg.sv
// Shared types, direction bit indices, default grid size and the wall bitmap
// for the maze player controller and any renderer-side ROM copies.
package maze_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOOKUP = 2'd1,
    EVAL   = 2'd2,
    DONE   = 2'd3
  } state_t;

  localparam int DIR_UP    = 3;
  localparam int DIR_DOWN  = 2;
  localparam int DIR_LEFT  = 1;
  localparam int DIR_RIGHT = 0;

  localparam int DEF_GRID_W = 16;
  localparam int DEF_GRID_H = 12;

  // One 16-bit word per row, row 0 in the low bits; bit x of a row is column x.
  // 1 = wall. Top and bottom rows are solid, plus two short interior walls.
  localparam logic [DEF_GRID_W*DEF_GRID_H-1:0] MAZE_MAP = {
    16'hFFFF,  // row 11
    16'h0000,  // row 10
    16'h0000,  // row 9
    16'h0000,  // row 8
    16'h0000,  // row 7
    16'h0180,  // row 6
    16'h0000,  // row 5
    16'h0000,  // row 4
    16'h0038,  // row 3
    16'h0000,  // row 2
    16'h0000,  // row 1
    16'hFFFF   // row 0
  };

  function automatic logic is_one_hot4(input logic [3:0] v);
    return (v != 4'd0) && ((v & (v - 4'd1)) == 4'd0);
  endfunction

endpackage

// File: rtl/maze_player_ctrl_if.sv
// Player-control bundle: direction pulses in, position/status/step count out,
// plus the controller state for observation.
interface maze_player_ctrl_if;
  // move_req carries one-cycle pulses with no ready: a pulse is taken only
  // when the controller is IDLE and exactly one bit is set; all others are dropped.
  logic [3:0]           move_req;
  logic [7:0]           player_x_pos;
  logic [7:0]           player_y_pos;
  logic                 moved;
  logic                 bumped;
  logic                 at_goal;
  logic                 busy;
  logic [15:0]          step_count;
  maze_pkg::state_t     state;

  modport master (
    output move_req,
    input  player_x_pos, player_y_pos, moved, bumped, at_goal, busy,
           step_count, state
  );

  modport slave (
    input  move_req,
    output player_x_pos, player_y_pos, moved, bumped, at_goal, busy,
           step_count, state
  );
endinterface

// File: rtl/maze_rom.sv
// Single-port wall-map ROM with a registered 1-cycle read.
// Addresses past the end of the map read as wall.
module maze_rom
  import maze_pkg::*;
#(
  parameter int                 DEPTH = DEF_GRID_W * DEF_GRID_H,
  parameter int                 AW    = $clog2(DEPTH),
  parameter logic [DEPTH-1:0]   INIT  = MAZE_MAP
) (
  input  logic          clk,
  input  logic [AW-1:0] addr,
  output logic          data
);

  logic data_d;
  logic data_q;

  always_comb begin
    data_d = 1'b1;
    if (int'(addr) < DEPTH) data_d = INIT[addr];
  end

  always_ff @(posedge clk) begin
    data_q <= data_d;
  end

  assign data = data_q;

endmodule

// File: rtl/maze_player_ctrl.sv
// Turns single-cycle direction pulses into checked tile moves: bounds check,
// wall lookup, commit or bump, goal detection and a saturating step counter.
module maze_player_ctrl
  import maze_pkg::*;
#(
  parameter int GRID_W  = DEF_GRID_W,
  parameter int GRID_H  = DEF_GRID_H,
  parameter int START_X = 1,
  parameter int START_Y = 1,
  parameter int GOAL_X  = 14,
  parameter int GOAL_Y  = 10
) (
  input  logic               clk,
  input  logic               reset,
  maze_player_ctrl_if.slave  bus
);

  localparam int          CELLS    = GRID_W * GRID_H;
  localparam int          AW       = $clog2(CELLS);
  localparam logic [7:0]  START_X8 = 8'(START_X);
  localparam logic [7:0]  START_Y8 = 8'(START_Y);
  localparam logic [7:0]  GOAL_X8  = 8'(GOAL_X);
  localparam logic [7:0]  GOAL_Y8  = 8'(GOAL_Y);

  state_t       state_q,  state_d;
  logic [7:0]   x_q,      x_d;
  logic [7:0]   y_q,      y_d;
  logic [7:0]   tx_q,     tx_d;
  logic [7:0]   ty_q,     ty_d;
  logic         oob_q,    oob_d;
  logic         moved_q,  moved_d;
  logic         bumped_q, bumped_d;
  logic         goal_q,   goal_d;
  logic         busy_q,   busy_d;
  logic [15:0]  steps_q,  steps_d;

  logic signed [8:0] nx;
  logic signed [8:0] ny;
  logic [AW-1:0]     rom_addr;
  logic              wall_bit;

  // Address is built from the latched target; only meaningful when the bounds check passed.
  assign rom_addr = AW'(int'(ty_q) * GRID_W + int'(tx_q));

  maze_rom #(
    .DEPTH (CELLS),
    .AW    (AW),
    .INIT  (MAZE_MAP[CELLS-1:0])
  ) u_rom (
    .clk  (clk),
    .addr (rom_addr),
    .data (wall_bit)
  );

  always_comb begin
    nx = $signed({1'b0, x_q});
    ny = $signed({1'b0, y_q});
    if (bus.move_req[DIR_UP])    ny = ny - 9'sd1;
    if (bus.move_req[DIR_DOWN])  ny = ny + 9'sd1;
    if (bus.move_req[DIR_LEFT])  nx = nx - 9'sd1;
    if (bus.move_req[DIR_RIGHT]) nx = nx + 9'sd1;
  end

  always_comb begin
    state_d  = state_q;
    x_d      = x_q;
    y_d      = y_q;
    tx_d     = tx_q;
    ty_d     = ty_q;
    oob_d    = oob_q;
    moved_d  = 1'b0;
    bumped_d = 1'b0;
    goal_d   = goal_q;
    busy_d   = 1'b0;
    steps_d  = steps_q;

    unique case (state_q)
      IDLE: begin
        if (is_one_hot4(bus.move_req)) begin
          tx_d    = nx[7:0];
          ty_d    = ny[7:0];
          oob_d   = (nx < 0) || (ny < 0) || (nx >= GRID_W) || (ny >= GRID_H);
          busy_d  = 1'b1;
          state_d = LOOKUP;
        end
      end
      LOOKUP: begin
        busy_d  = 1'b1;
        state_d = EVAL;
      end
      EVAL: begin
        state_d = IDLE;
        if (oob_q || wall_bit) begin
          bumped_d = 1'b1;
        end else begin
          x_d     = tx_q;
          y_d     = ty_q;
          moved_d = 1'b1;
          if (steps_q != 16'hFFFF) steps_d = steps_q + 16'd1;
          if (tx_q == GOAL_X8 && ty_q == GOAL_Y8) begin
            goal_d  = 1'b1;
            state_d = DONE;
          end
        end
      end
      DONE: begin
        state_d = DONE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      x_q      <= START_X8;
      y_q      <= START_Y8;
      tx_q     <= START_X8;
      ty_q     <= START_Y8;
      oob_q    <= 1'b0;
      moved_q  <= 1'b0;
      bumped_q <= 1'b0;
      goal_q   <= 1'b0;
      busy_q   <= 1'b0;
      steps_q  <= 16'd0;
    end else begin
      state_q  <= state_d;
      x_q      <= x_d;
      y_q      <= y_d;
      tx_q     <= tx_d;
      ty_q     <= ty_d;
      oob_q    <= oob_d;
      moved_q  <= moved_d;
      bumped_q <= bumped_d;
      goal_q   <= goal_d;
      busy_q   <= busy_d;
      steps_q  <= steps_d;
    end
  end

  assign bus.player_x_pos = x_q;
  assign bus.player_y_pos = y_q;
  assign bus.moved        = moved_q;
  assign bus.bumped       = bumped_q;
  assign bus.at_goal      = goal_q;
  assign bus.busy         = busy_q;
  assign bus.step_count   = steps_q;
  assign bus.state        = state_q;

endmodule
